tmds_encoder_8b10b: RTL and testbench

TMDS_ENCODER_8B10B -- requirements
Module: tmds_encoder_8b10b

---
 rtl/tmds_encoder_8b10b.sv | 128 ++++++++++++
 tb/tb_tmds_encoder_8b10b.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_8b10b.sv
// TMDS 8b/10b channel encoder: three-stage pipeline producing one
// DVI/HDMI character per pixel clock with running-disparity tracking.
module tmds_encoder_8b10b (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              c0,
  input  logic              c1,
  input  logic              de,
  output logic [9:0]        q_out,
  output logic              de_out,
  output logic signed [4:0] disp
);

  logic [7:0]        din_q;
  logic [3:0]        n1d_q, n1d_d;
  logic [1:0]        c_s1_q;
  logic              de_s1_q;

  logic [8:0]        qm_q, qm_d;
  logic [1:0]        c_s2_q;
  logic              de_s2_q;

  logic [9:0]        q_out_q, q_out_d;
  logic              de_out_q;
  logic signed [4:0] disp_q, disp_d;

  logic              use_xnor;
  logic              acc;
  logic [3:0]        n1q, n0q;
  logic signed [4:0] diff;
  logic signed [4:0] two;
  logic              bal;
  logic              same_sign;

  always_comb begin
    n1d_d = '0;
    for (int i = 0; i < 8; i++)
      n1d_d = n1d_d + {3'b000, din[i]};
  end

  // Minimise transitions: XNOR chaining when the byte is ones-heavy.
  always_comb begin
    use_xnor = (n1d_q > 4'd4) ||
               ((n1d_q == 4'd4) && !din_q[0]);
    acc      = din_q[0];
    qm_d     = '0;
    qm_d[0]  = acc;
    for (int i = 1; i < 8; i++) begin
      acc     = use_xnor ? ~(acc ^ din_q[i])
                         :  (acc ^ din_q[i]);
      qm_d[i] = acc;
    end
    qm_d[8] = ~use_xnor;
  end

  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++)
      n1q = n1q + {3'b000, qm_q[i]};
  end

  assign n0q  = 4'd8 - n1q;
  assign diff = $signed({1'b0, n1q})
              - $signed({1'b0, n0q});
  assign two  = qm_q[8] ? 5'sd2 : 5'sd0;
  assign bal  = (disp_q == 5'sd0) || (n1q == n0q);
  assign same_sign =
    ((disp_q > 5'sd0) && (n1q > n0q)) ||
    ((disp_q < 5'sd0) && (n0q > n1q));

  // Inversion choice steers the running disparity back toward zero.
  always_comb begin
    q_out_d = '0;
    disp_d  = disp_q;
    if (!de_s2_q) begin
      disp_d = 5'sd0;
      case (c_s2_q)
        2'b00:   q_out_d = 10'b1101010100;
        2'b01:   q_out_d = 10'b0010101011;
        2'b10:   q_out_d = 10'b0101010100;
        default: q_out_d = 10'b1010101011;
      endcase
    end else if (bal) begin
      q_out_d = {~qm_q[8], qm_q[8],
                 qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      disp_d  = qm_q[8] ? disp_q + diff
                        : disp_q - diff;
    end else if (same_sign) begin
      q_out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      disp_d  = disp_q + two - diff;
    end else begin
      q_out_d = {1'b0, qm_q[8], qm_q[7:0]};
      disp_d  = disp_q - (5'sd2 - two) + diff;
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      din_q    <= '0;
      n1d_q    <= '0;
      c_s1_q   <= '0;
      de_s1_q  <= 1'b0;
      qm_q     <= '0;
      c_s2_q   <= '0;
      de_s2_q  <= 1'b0;
      q_out_q  <= '0;
      de_out_q <= 1'b0;
      disp_q   <= '0;
    end else begin
      din_q    <= din;
      n1d_q    <= n1d_d;
      c_s1_q   <= {c1, c0};
      de_s1_q  <= de;
      qm_q     <= qm_d;
      c_s2_q   <= c_s1_q;
      de_s2_q  <= de_s1_q;
      q_out_q  <= q_out_d;
      de_out_q <= de_s2_q;
      disp_q   <= disp_d;
    end
  end

  assign q_out  = q_out_q;
  assign de_out = de_out_q;
  assign disp   = disp_q;

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Directed and randomised checks of the TMDS channel encoder against
// hand-computed characters, a behavioural model and a DVI decoder.
module tb_tmds_encoder_8b10b;

  logic              pix_clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        din = '0;
  logic              c0 = 1'b0;
  logic              c1 = 1'b0;
  logic              de = 1'b0;
  logic [9:0]        q_out;
  logic              de_out;
  logic signed [4:0] disp;

  int n_cmp = 0;
  int n_err = 0;
  int model_rd = 0;

  typedef struct {
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
  } stim_t;

  typedef struct {
    logic [9:0] q;
    logic       de;
    logic [4:0] disp;
    logic [7:0] d;
  } exp_t;

  tmds_encoder_8b10b dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .din     (din),
    .c0      (c0),
    .c1      (c1),
    .de      (de),
    .q_out   (q_out),
    .de_out  (de_out),
    .disp    (disp)
  );

  always #5 pix_clk = ~pix_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic e, input logic [1:0] c,
                       input logic [7:0] d);
    de = e;
    {c1, c0} = c;
    din = d;
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'b00, 8'h00);
    repeat (n) tick();
  endtask

  function automatic logic [7:0] dvi_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++)
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic ref_enc(input stim_t s, output logic [9:0] q);
    int n1, n1q, n0q;
    logic [8:0] m;
    logic x;
    q = '0;
    if (!s.de) begin
      model_rd = 0;
      case (s.c)
        2'd0: q = 10'h354;
        2'd1: q = 10'h0AB;
        2'd2: q = 10'h154;
        default: q = 10'h2AB;
      endcase
    end else begin
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(s.d[i]);
      x = (n1 > 4) || (n1 == 4 && !s.d[0]);
      m[0] = s.d[0];
      for (int i = 1; i < 8; i++)
        m[i] = x ? ~(m[i-1] ^ s.d[i]) : (m[i-1] ^ s.d[i]);
      m[8] = ~x;
      n1q = 0;
      for (int i = 0; i < 8; i++) n1q += int'(m[i]);
      n0q = 8 - n1q;
      if (model_rd == 0 || n1q == n0q) begin
        q = {~m[8], m[8], m[8] ? m[7:0] : ~m[7:0]};
        model_rd += m[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((model_rd > 0 && n1q > n0q) ||
                   (model_rd < 0 && n0q > n1q)) begin
        q = {1'b1, m[8], ~m[7:0]};
        model_rd += 2 * int'(m[8]) + n0q - n1q;
      end else begin
        q = {1'b0, m[8], m[7:0]};
        model_rd += -2 * int'(!m[8]) + n1q - n0q;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b11, 8'hA5);
    repeat (3) tick();
    n_cmp++;
    if (q_out !== 10'h000) begin
      n_err++;
      $display("FAIL reset_q: got %h expected 000", q_out);
    end
    n_cmp++;
    if (de_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_de: got %b expected 0", de_out);
    end
    n_cmp++;
    if (disp !== 5'sd0) begin
      n_err++;
      $display("FAIL reset_disp: got %0d expected 0", disp);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_control();
    logic [9:0] exp_q [4];
    exp_q = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b0, k[1:0], 8'h5A);
      else drive(1'b0, 2'b00, 8'h00);
      tick();
      if (k >= 2) begin
        n_cmp++;
        if (q_out !== exp_q[k-2]) begin
          n_err++;
          $display("FAIL ctrl_q[%0d]: got %h expected %h",
                   k - 2, q_out, exp_q[k-2]);
        end
        n_cmp++;
        if (disp !== 5'sd0 || de_out !== 1'b0) begin
          n_err++;
          $display("FAIL ctrl_disp_de[%0d]: got %0d/%b expected 0/0",
                   k - 2, disp, de_out);
        end
      end
    end
  endtask

  task automatic test_disparity_pair();
    logic [9:0] exp_q [2];
    logic [4:0] exp_d [2];
    exp_q = '{10'h100, 10'h3FF};
    exp_d = '{5'h18, 5'h02};
    idle(3);
    for (int k = 0; k < 4; k++) begin
      if (k < 2) drive(1'b1, 2'b00, 8'h00);
      else drive(1'b0, 2'b00, 8'h00);
      tick();
      if (k >= 2) begin
        n_cmp++;
        if (q_out !== exp_q[k-2] || disp !== exp_d[k-2] ||
            de_out !== 1'b1) begin
          n_err++;
          $display("FAIL pair[%0d]: got %h/%0d/%b expected %h/%0d/1",
                   k - 2, q_out, disp, de_out, exp_q[k-2],
                   $signed(exp_d[k-2]));
        end
      end
    end
  endtask

  task automatic test_xnor();
    idle(3);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive(1'b1, 2'b00, 8'hFF);
      else drive(1'b0, 2'b00, 8'h00);
      tick();
    end
    n_cmp++;
    if (q_out !== 10'h200 || disp !== 5'h18 || de_out !== 1'b1) begin
      n_err++;
      $display("FAIL xnor: got %h/%0d/%b expected 200/-8/1",
               q_out, disp, de_out);
    end
  endtask

  task automatic test_ctrl_ignored();
    logic [9:0] exp_q [2];
    logic [4:0] exp_d [2];
    exp_q = '{10'h100, 10'h3FF};
    exp_d = '{5'h18, 5'h02};
    idle(3);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 2'b11, 8'h00);
      else if (k == 1) drive(1'b1, 2'b01, 8'h00);
      else drive(1'b0, 2'b00, 8'h00);
      tick();
      if (k >= 2) begin
        n_cmp++;
        if (q_out !== exp_q[k-2] || disp !== exp_d[k-2]) begin
          n_err++;
          $display("FAIL ctrl_ignored[%0d]: got %h/%0d expected %h/%0d",
                   k - 2, q_out, disp, exp_q[k-2],
                   $signed(exp_d[k-2]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t      v [4];
    logic [9:0] exp_q [4];
    logic [4:0] exp_d [4];
    logic       exp_e [4];
    v = '{'{1'b1, 2'b00, 8'hFF}, '{1'b0, 2'b01, 8'h00},
          '{1'b1, 2'b10, 8'h00}, '{1'b1, 2'b00, 8'hFF}};
    exp_q = '{10'h200, 10'h0AB, 10'h100, 10'h0FF};
    exp_d = '{5'h18, 5'h00, 5'h18, 5'h1E};
    exp_e = '{1'b1, 1'b0, 1'b1, 1'b1};
    idle(3);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(v[k].de, v[k].c, v[k].d);
      else drive(1'b0, 2'b00, 8'h00);
      tick();
      if (k >= 2) begin
        n_cmp++;
        if (q_out !== exp_q[k-2] || disp !== exp_d[k-2] ||
            de_out !== exp_e[k-2]) begin
          n_err++;
          $display("FAIL b2b[%0d]: got %h/%0d/%b expected %h/%0d/%b",
                   k - 2, q_out, disp, de_out, exp_q[k-2],
                   $signed(exp_d[k-2]), exp_e[k-2]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    idle(3);
    drive(1'b1, 2'b00, 8'h00);
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (q_out !== 10'h000 || de_out !== 1'b0 || disp !== 5'sd0) begin
      n_err++;
      $display("FAIL midrst_clear: got %h/%b/%0d expected 000/0/0",
               q_out, de_out, disp);
    end
    tick();
    tick();
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) begin
        n_cmp++;
        if (de_out !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_partial[%0d]: got de_out %b expected 0",
                   k, de_out);
        end
      end else begin
        n_cmp++;
        if (q_out !== 10'h100 || disp !== 5'h18 || de_out !== 1'b1) begin
          n_err++;
          $display("FAIL midrst_first: got %h/%0d/%b expected 100/-8/1",
                   q_out, disp, de_out);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    sent;
    int    dv;
    sent = 0;
    while (sent < 10000) begin
      for (int p = 0; p < 1920 && sent < 10000; p++) begin
        s.de = 1'b1;
        s.c  = 2'($urandom);
        s.d  = 8'($urandom);
        sq.push_back(s);
        sent++;
      end
      for (int b = 0; b < 280; b++) begin
        s.de = 1'b0;
        s.c  = 2'($urandom);
        s.d  = 8'($urandom);
        sq.push_back(s);
      end
    end
    s = '{1'b0, 2'b00, 8'h00};
    sq.push_back(s);
    sq.push_back(s);
    idle(3);
    model_rd = 0;
    for (int i = 0; i < sq.size(); i++) begin
      drive(sq[i].de, sq[i].c, sq[i].d);
      ref_enc(sq[i], e.q);
      e.de   = sq[i].de;
      e.disp = 5'(model_rd);
      e.d    = sq[i].d;
      eq.push_back(e);
      tick();
      if (eq.size() == 3) begin
        o = eq.pop_front();
        n_cmp++;
        if (q_out !== o.q || de_out !== o.de) begin
          n_err++;
          $display("FAIL rand_q[%0d]: got %h/%b expected %h/%b",
                   i, q_out, de_out, o.q, o.de);
        end
        n_cmp++;
        if (disp !== o.disp) begin
          n_err++;
          $display("FAIL rand_disp[%0d]: got %0d expected %0d",
                   i, disp, $signed(o.disp));
        end
        dv = int'(disp);
        n_cmp++;
        if (dv > 10 || dv < -10) begin
          n_err++;
          $display("FAIL rand_bound[%0d]: got %0d expected |disp|<=10",
                   i, dv);
        end
        if (o.de) begin
          n_cmp++;
          if (dvi_decode(q_out) !== o.d) begin
            n_err++;
            $display("FAIL rand_decode[%0d]: got %h expected %h",
                     i, dvi_decode(q_out), o.d);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_control();
    test_disparity_pair();
    test_xnor();
    test_ctrl_ignored();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
